if_fetch_unit: RTL

//  Instruction-fetch stage: owns the PC, issues single-word reads to instruction memory, and delivers
//  one instruction at a time to the decode stage over the kick-up handshake. It is the producer end of
//  `instruction` / IF_ID_kick_up and the consumer of EX_kick_up / EX_flush / EX_branch_target.

---
 rtl/if_fetch_unit_pkg.sv | 29 ++
 rtl/if_fetch_unit_if.sv | 44 ++++
 rtl/if_pc_gen.sv | 39 +++
 rtl/if_fetch_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: opcode constants, reset defaults
// and the fetch-state encoding.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  // RV32I major opcodes, shared with decode.
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // REQ: issue read; WAIT: read outstanding; FULL: instruction held;
  // DRAIN: a flushed read is still owed and must be swallowed.
  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StWait  = 2'd1,
    StFull  = 2'd2,
    StDrain = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch stage's memory, decode and execute-redirect signals.
// master = the fetch unit, slave = its environment (memory, decode, execute).
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        EX_kick_up;
  logic        EX_flush;
  logic [31:0] EX_branch_target;

  logic [31:0] instruction;
  logic [31:0] IF_pc;
  logic        IF_ID_kick_up;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata,
    input  EX_kick_up,
    input  EX_flush,
    input  EX_branch_target,
    output instruction,
    output IF_pc,
    output IF_ID_kick_up
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata,
    output EX_kick_up,
    output EX_flush,
    output EX_branch_target,
    input  instruction,
    input  IF_pc,
    input  IF_ID_kick_up
  );

endinterface

// File: rtl/if_pc_gen.sv
// Fetch PC register: sequential increment on a completed fetch, redirect on flush.
module if_pc_gen
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  // Redirect wins over increment; arithmetic wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (flush_i) begin
      pc_d = target_i;
    end else if (advance_i) begin
      pc_d = pc_q + PC_STEP[31:0];
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding read, one held instruction, flush-driven redirect.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  if_fetch_unit_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic         valid_q, valid_d;
  logic         kick_q, kick_d;
  logic         first_done_q, first_done_d;

  logic [31:0]  pc;
  logic         pc_advance;
  logic         consume;

  if_pc_gen #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .clk       (clk),
    .reset     (reset),
    .advance_i (pc_advance),
    .flush_i   (bus.EX_flush),
    .target_i  (bus.EX_branch_target),
    .pc_o      (pc)
  );

  // The first hand-off is taken implicitly by decode; afterwards it must acknowledge.
  assign consume = first_done_q ? bus.EX_kick_up : kick_q;

  // Next-state and held-instruction update; flush overrides everything.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    if_pc_d      = if_pc_q;
    valid_d      = valid_q;
    kick_d       = 1'b0;
    first_done_d = first_done_q | kick_q;
    pc_advance   = 1'b0;

    if (bus.EX_flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      if_pc_d = 32'h0;
      unique case (state_q)
        // A read still owed after flush must be drained before the redirected request.
        StWait, StDrain: state_d = bus.imem_rvalid ? StReq : StDrain;
        default:         state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          state_d = StWait;
        end
        StWait: begin
          if (bus.imem_rvalid) begin
            instr_d    = bus.imem_rdata;
            if_pc_d    = pc;
            valid_d    = 1'b1;
            kick_d     = 1'b1;
            pc_advance = 1'b1;
            state_d    = StFull;
          end
        end
        StFull: begin
          if (consume) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if_pc_d = 32'h0;
            state_d = StReq;
          end
        end
        StDrain: begin
          if (bus.imem_rvalid) begin
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StReq;
      instr_q      <= NOP_INSTR;
      if_pc_q      <= 32'h0;
      valid_q      <= 1'b0;
      kick_q       <= 1'b0;
      first_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      if_pc_q      <= if_pc_d;
      valid_q      <= valid_d;
      kick_q       <= kick_d;
      first_done_q <= first_done_d;
    end
  end

  // Request is suppressed in a flush cycle so the stale PC never reaches memory.
  always_comb begin
    bus.imem_req      = (state_q == StReq) && !bus.EX_flush;
    bus.imem_addr     = pc;
    bus.instruction   = valid_q ? instr_q : NOP_INSTR;
    bus.IF_pc         = valid_q ? if_pc_q : 32'h0;
    bus.IF_ID_kick_up = kick_q;
  end

endmodule
